// File: rtl/fprint_dma_pkg.sv
// Shared definitions for the scratchpad DMA loader: CSR map, control/status bits and FSM states.
package fprint_dma_pkg;

  localparam logic [1:0] CSR_SRC  = 2'd0;
  localparam logic [1:0] CSR_DST  = 2'd1;
  localparam logic [1:0] CSR_LEN  = 2'd2;
  localparam logic [1:0] CSR_CTRL = 2'd3;

  localparam int unsigned CTRL_GO     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_CLEAR  = 2;

  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_IRQ_EN = 1;
  localparam int unsigned STAT_DONE   = 2;
  localparam int unsigned STAT_ERROR  = 3;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} dma_state_e;

endpackage

// File: rtl/fprint_scratchpad_dma_loader.sv
// Avalon-MM read DMA that copies a block of main memory into consecutive scratchpad words,
// programmed through a 4-word CSR slave and signalling completion with a level interrupt.
module fprint_scratchpad_dma_loader
  import fprint_dma_pkg::*;
#(
  parameter int unsigned SPAD_DEPTH      = 4096,
  parameter int unsigned SPAD_AW         = 12,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         csr_address,
  input  logic               csr_read,
  input  logic               csr_write,
  input  logic [31:0]        csr_writedata,
  output logic [31:0]        csr_readdata,
  output logic [31:0]        m_address,
  output logic               m_read,
  input  logic               m_waitrequest,
  input  logic [31:0]        m_readdata,
  input  logic               m_readdatavalid,
  output logic [SPAD_AW-1:0] spad_address,
  output logic [3:0]         spad_byteenable,
  output logic               spad_chipselect,
  output logic               spad_write,
  output logic [31:0]        spad_writedata,
  output logic               spad_clken,
  output logic               irq
);

  localparam int unsigned CW = SPAD_AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MaxOut = OW'(MAX_OUTSTANDING);
  localparam logic [SPAD_AW+1:0] DepthLimit = (SPAD_AW + 2)'(SPAD_DEPTH);

  dma_state_e         state_q;
  logic [31:0]        src_q;
  logic [SPAD_AW-1:0] dst_q;
  logic [CW-1:0]      len_q, issued_q, received_q, issued_d;
  logic [OW-1:0]      outstanding_q, outstanding_d;
  logic               irq_en_q, done_q, error_q, irq_q;
  logic               irq_en_d, done_d, error_d;
  logic               m_read_q, spad_write_q;
  logic [31:0]        m_address_q, spad_writedata_q, csr_readdata_q, csr_rdata;
  logic [SPAD_AW-1:0] spad_address_q;
  logic [SPAD_AW+1:0] end_word;
  logic               busy, accept, resp, ctrl_wr, go, bounds_err, len_zero, go_launch;
  logic               drain_done;

  assign busy       = (state_q != StIdle);
  assign accept     = m_read_q & ~m_waitrequest;
  // Responses outside a transfer are leftovers from before a reset and must not be written.
  assign resp       = m_readdatavalid & busy;
  assign ctrl_wr    = csr_write & (csr_address == CSR_CTRL);
  assign go         = ctrl_wr & csr_writedata[CTRL_GO] & ~busy;
  assign end_word   = {2'b00, dst_q} + {1'b0, len_q};
  assign bounds_err = end_word > DepthLimit;
  assign len_zero   = (len_q == '0);
  assign go_launch  = go & ~bounds_err & ~len_zero;
  assign drain_done = (state_q == StDrain) && (received_q == len_q) && (outstanding_q == '0);

  assign outstanding_d = outstanding_q + OW'(accept) - OW'(resp);
  assign issued_d      = issued_q + CW'(accept);

  always_comb begin
    done_d   = done_q;
    error_d  = error_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      irq_en_d = csr_writedata[CTRL_IRQ_EN];
      if (csr_writedata[CTRL_CLEAR]) begin
        done_d  = 1'b0;
        error_d = 1'b0;
      end
    end
    if (go) begin
      if (bounds_err) begin
        done_d  = 1'b1;
        error_d = 1'b1;
      end else if (len_zero) begin
        done_d  = 1'b1;
      end else begin
        done_d  = 1'b0;
        error_d = 1'b0;
      end
    end
    if (drain_done) done_d = 1'b1;
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_address)
      CSR_SRC: csr_rdata = src_q;
      CSR_DST: csr_rdata = 32'(dst_q);
      CSR_LEN: csr_rdata = 32'(len_q);
      default: begin
        csr_rdata[STAT_BUSY]   = busy;
        csr_rdata[STAT_IRQ_EN] = irq_en_q;
        csr_rdata[STAT_DONE]   = done_q;
        csr_rdata[STAT_ERROR]  = error_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      src_q            <= '0;
      dst_q            <= '0;
      len_q            <= '0;
      issued_q         <= '0;
      received_q       <= '0;
      outstanding_q    <= '0;
      irq_en_q         <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      irq_q            <= 1'b0;
      m_read_q         <= 1'b0;
      m_address_q      <= '0;
      spad_write_q     <= 1'b0;
      spad_address_q   <= '0;
      spad_writedata_q <= '0;
      csr_readdata_q   <= '0;
    end else begin
      done_q        <= done_d;
      error_q       <= error_d;
      irq_en_q      <= irq_en_d;
      irq_q         <= done_d & irq_en_d;
      outstanding_q <= outstanding_d;
      spad_write_q  <= resp;
      if (csr_read) csr_readdata_q <= csr_rdata;
      if (csr_write && !busy) begin
        case (csr_address)
          CSR_SRC: src_q <= {csr_writedata[31:2], 2'b00};
          CSR_DST: dst_q <= csr_writedata[SPAD_AW-1:0];
          CSR_LEN: len_q <= csr_writedata[CW-1:0];
          default: ;
        endcase
      end
      if (resp) begin
        spad_address_q   <= dst_q + received_q[SPAD_AW-1:0];
        spad_writedata_q <= m_readdata;
        received_q       <= received_q + CW'(1);
      end
      case (state_q)
        StIdle: begin
          if (go_launch) begin
            state_q       <= StIssue;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
            m_read_q      <= 1'b1;
            m_address_q   <= src_q;
          end
        end
        StIssue: begin
          issued_q    <= issued_d;
          m_address_q <= src_q + 32'({issued_d, 2'b00});
          if (accept && (issued_d == len_q)) begin
            state_q  <= StDrain;
            m_read_q <= 1'b0;
          end else begin
            // A held request already had room when raised, so this never drops it mid-stall.
            m_read_q <= (outstanding_d < MaxOut);
          end
        end
        StDrain: begin
          if (drain_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign csr_readdata    = csr_readdata_q;
  assign m_address       = m_address_q;
  assign m_read          = m_read_q;
  assign spad_address    = spad_address_q;
  assign spad_byteenable = 4'hF;
  assign spad_chipselect = spad_write_q;
  assign spad_write      = spad_write_q;
  assign spad_writedata  = spad_writedata_q;
  assign spad_clken      = 1'b1;
  assign irq             = irq_q;

endmodule

// File: tb/tb_fprint_scratchpad_dma_loader.sv
// Directed bench for the scratchpad DMA loader with a latency/backpressure memory model.
module tb_fprint_scratchpad_dma_loader;
  import fprint_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  csr_address = '0;
  logic        csr_read = 1'b0;
  logic        csr_write = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic [31:0] csr_readdata;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic [11:0] spad_address;
  logic [3:0]  spad_byteenable;
  logic        spad_chipselect;
  logic        spad_write;
  logic [31:0] spad_writedata;
  logic        spad_clken;
  logic        irq;

  fprint_scratchpad_dma_loader #(
    .SPAD_DEPTH     (4096),
    .SPAD_AW        (12),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .csr_address    (csr_address),
    .csr_read       (csr_read),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .csr_readdata   (csr_readdata),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .spad_address   (spad_address),
    .spad_byteenable(spad_byteenable),
    .spad_chipselect(spad_chipselect),
    .spad_write     (spad_write),
    .spad_writedata (spad_writedata),
    .spad_clken     (spad_clken),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Memory model and scratchpad monitor, all evaluated on the falling edge.
  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       rq[$];
  int          cyc = 0;
  int          wait_pct = 0;
  int          lat = 1;
  logic [31:0] exp_src = '0;
  int          exp_dst = 0;
  int          n_wr = 0, n_acc = 0, n_mread = 0;
  int          first_rv = -1, first_wr = -1;
  logic [11:0] last_addr = '0;
  bit          chk_en = 1'b1;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [31:0] ew;
    if (chk_en && prev_stall) begin
      check("stall_m_read", 32'(m_read), 32'd1);
      check("stall_m_address", m_address, prev_addr);
    end
    if (spad_write) begin
      if (chk_en) begin
        ew = exp_src + 32'(4 * n_wr);
        check("spad_address", 32'(spad_address), 32'(exp_dst + n_wr));
        check("spad_writedata", spad_writedata, ew ^ 32'hA5A5A5A5);
        check("spad_chipselect", 32'(spad_chipselect), 32'd1);
      end
      if (first_wr < 0) first_wr = cyc;
      last_addr = spad_address;
      n_wr++;
    end
    if (m_read) n_mread++;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      m_readdatavalid = 1'b1;
      m_readdata = rq[0].data;
      void'(rq.pop_front());
      if (first_rv < 0) first_rv = cyc;
    end else begin
      m_readdatavalid = 1'b0;
      m_readdata = $urandom;
    end
    m_waitrequest = ($urandom_range(99) < wait_pct);
    if (m_read && !m_waitrequest) begin
      if (chk_en) check("m_address", m_address, exp_src + 32'(4 * n_acc));
      rq.push_back('{m_address ^ 32'hA5A5A5A5, cyc + lat});
      n_acc++;
      if (chk_en) begin
        n_vec++;
        if (rq.size() > 4) begin
          n_err++;
          $display("FAIL outstanding: %0d in flight, limit 4", rq.size());
        end
      end
    end
    prev_stall = m_read && m_waitrequest;
    prev_addr = m_address;
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address = a;
    csr_writedata = d;
    csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_address = a;
    csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic clear_counts();
    n_wr = 0;
    n_acc = 0;
    n_mread = 0;
    first_rv = -1;
    first_wr = -1;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] st;
    bit          idle;
    idle = 1'b0;
    for (int i = 0; i < 20000 && !idle; i++) begin
      csr_rd(CSR_CTRL, st);
      idle = !st[STAT_BUSY];
    end
    if (!idle) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: still busy, want idle", name);
    end
  endtask

  typedef struct {
    logic [31:0] src;
    int          dst;
    int          len;
    int          lat;
    int          wp;
    bit          irq_en;
    bit          exp_err;
    bit          exp_done;
    int          exp_words;
  } xfer_t;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } csr_vec_t;

  xfer_t    xv[7];
  csr_vec_t cv[6];

  initial begin
    logic [31:0] rd, st_exp;
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, st_exp;

    cv[0] = '{CSR_SRC,  32'h1234_5677, 32'h1234_5674};
    cv[1] = '{CSR_DST,  32'hFFFF_FABC, 32'h0000_0ABC};
    cv[2] = '{CSR_LEN,  32'hFFFF_3FFF, 32'h0000_1FFF};
    cv[3] = '{CSR_SRC,  32'hFFFF_FFFF, 32'hFFFF_FFFC};
    cv[4] = '{CSR_CTRL, 32'h0000_0002, 32'h0000_0002};
    cv[5] = '{CSR_CTRL, 32'h0000_0000, 32'h0000_0000};

    //         src            dst   len   lat wp  irq err done words
    xv[0] = '{32'h0000_1000,  0,    8,    1,  0,  1,  0,  1,   8};
    xv[1] = '{32'h2000_0000,  100,  64,   5,  50, 0,  0,  1,   64};
    xv[2] = '{32'h0000_5000,  4090, 7,    1,  0,  1,  1,  1,   0};
    xv[3] = '{32'h0000_6000,  0,    0,    1,  0,  1,  0,  1,   0};
    xv[4] = '{32'hFFFF_FFF0,  4000, 96,   2,  25, 1,  0,  1,   96};
    xv[5] = '{32'h0000_8000,  4089, 7,    3,  30, 0,  0,  1,   7};
    xv[6] = '{32'h0001_0000,  0,    4096, 1,  0,  1,  0,  1,   4096};

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_m_address", m_address, 32'd0);
    check("rst_spad_write", 32'(spad_write), 32'd0);
    check("rst_spad_byteenable", 32'(spad_byteenable), 32'hF);
    check("rst_spad_clken", 32'(spad_clken), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    csr_rd(CSR_CTRL, rd);
    check("rst_status", rd, 32'd0);

    for (int i = 0; i < 6; i++) begin
      csr_wr(cv[i].addr, cv[i].wdata);
      csr_rd(cv[i].addr, rd);
      check($sformatf("csr_vec%0d", i), rd, cv[i].rdata);
    end

    for (int i = 0; i < 7; i++) begin
      wait_pct = xv[i].wp;
      lat = xv[i].lat;
      exp_src = xv[i].src;
      exp_dst = xv[i].dst;
      csr_wr(CSR_SRC, xv[i].src);
      csr_wr(CSR_DST, 32'(xv[i].dst));
      csr_wr(CSR_LEN, 32'(xv[i].len));
      csr_wr(CSR_CTRL, 32'h4);
      clear_counts();
      csr_wr(CSR_CTRL, {30'd0, xv[i].irq_en, 1'b1});
      if (xv[i].exp_words == 0)
        check($sformatf("xfer%0d_irq_next_cycle", i), 32'(irq), 32'(xv[i].irq_en));
      wait_idle($sformatf("xfer%0d", i));
      csr_rd(CSR_CTRL, rd);
      st_exp = {28'd0, xv[i].exp_err, xv[i].exp_done, xv[i].irq_en, 1'b0};
      check($sformatf("xfer%0d_status", i), rd, st_exp);
      check($sformatf("xfer%0d_irq", i), 32'(irq), 32'(xv[i].exp_done & xv[i].irq_en));
      check($sformatf("xfer%0d_writes", i), 32'(n_wr), 32'(xv[i].exp_words));
      check($sformatf("xfer%0d_reads", i), 32'(n_acc), 32'(xv[i].exp_words));
      if (xv[i].exp_words == 0) begin
        check($sformatf("xfer%0d_m_read_cycles", i), 32'(n_mread), 32'd0);
      end else begin
        check($sformatf("xfer%0d_last_addr", i), 32'(last_addr),
              32'(xv[i].dst + xv[i].len - 1));
        check($sformatf("xfer%0d_wb_latency", i), 32'(first_wr - first_rv), 32'd1);
      end
    end
    wait_pct = 0;

    // Clear drops DONE/ERROR; IRQ_EN follows the written bit.
    csr_wr(CSR_CTRL, 32'h4);
    csr_rd(CSR_CTRL, rd);
    check("clear_status", rd, 32'd0);
    check("clear_irq", 32'(irq), 32'd0);

    // Clear and GO in one write: clear first, then the bounds error sets both flags again.
    csr_wr(CSR_DST, 32'd4090);
    csr_wr(CSR_LEN, 32'd7);
    clear_counts();
    csr_wr(CSR_CTRL, 32'h7);
    check("go_clear_irq", 32'(irq), 32'd1);
    csr_rd(CSR_CTRL, rd);
    check("go_clear_status", rd, 32'h0000_000E);
    check("go_clear_m_read_cycles", 32'(n_mread), 32'd0);
    check("go_clear_writes", 32'(n_wr), 32'd0);

    // GO and SRC written mid-transfer are ignored.
    lat = 5;
    exp_src = 32'h0000_3000;
    exp_dst = 8;
    csr_wr(CSR_CTRL, 32'h4);
    csr_wr(CSR_SRC, 32'h0000_3000);
    csr_wr(CSR_DST, 32'd8);
    csr_wr(CSR_LEN, 32'd16);
    clear_counts();
    csr_wr(CSR_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    csr_wr(CSR_SRC, 32'h0000_9000);
    csr_wr(CSR_CTRL, 32'h1);
    wait_idle("busy_go");
    check("busy_go_writes", 32'(n_wr), 32'd16);
    check("busy_go_reads", 32'(n_acc), 32'd16);
    csr_rd(CSR_SRC, rd);
    check("busy_go_src", rd, 32'h0000_3000);
    csr_rd(CSR_CTRL, rd);
    check("busy_go_status", rd, 32'h0000_0004);

    // Reset mid-transfer after 10 of 32 words.
    exp_src = 32'h0000_4000;
    exp_dst = 0;
    csr_wr(CSR_SRC, 32'h0000_4000);
    csr_wr(CSR_DST, 32'd0);
    csr_wr(CSR_LEN, 32'd32);
    clear_counts();
    csr_wr(CSR_CTRL, 32'h3);
    for (int i = 0; i < 1000 && n_wr < 10; i++) @(negedge clk);
    check("rst_mid_reached_10", 32'(n_wr >= 10), 32'd1);
    chk_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_m_read", 32'(m_read), 32'd0);
    check("rst_mid_m_address", m_address, 32'd0);
    check("rst_mid_spad_write", 32'(spad_write), 32'd0);
    check("rst_mid_spad_chipselect", 32'(spad_chipselect), 32'd0);
    check("rst_mid_spad_address", 32'(spad_address), 32'd0);
    check("rst_mid_spad_writedata", spad_writedata, 32'd0);
    check("rst_mid_spad_byteenable", 32'(spad_byteenable), 32'hF);
    check("rst_mid_spad_clken", 32'(spad_clken), 32'd1);
    check("rst_mid_irq", 32'(irq), 32'd0);
    check("rst_mid_csr_readdata", csr_readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n_wr = 0;
    check("rst_mid_stale_pending", 32'(rq.size() > 0), 32'd1);
    repeat (20) @(negedge clk);
    check("rst_mid_stale_writes", 32'(n_wr), 32'd0);
    csr_rd(CSR_CTRL, rd);
    check("rst_mid_status", rd, 32'd0);
    rq.delete();
    chk_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
